// File: rtl/muxn_scan_if.sv
// Handshake/data bundle between a producer and the muxn_scan channel multiplexer.
interface muxn_scan_if #(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int SW = 2
);
    logic             CE;
    logic [N*W-1:0]   D;
    logic [SW-1:0]    S;
    logic             MODE;
    logic [N-1:0]     MASK;
    logic             QR;
    logic [W-1:0]     Q;
    logic [SW-1:0]    QCH;
    logic             QV;
    logic             QF;

    modport master (output CE, D, S, MODE, MASK, QR, input  Q, QCH, QV, QF);
    modport slave  (input  CE, D, S, MODE, MASK, QR, output Q, QCH, QV, QF);
endinterface

// File: rtl/muxn_scan.sv
// N-channel W-bit registered multiplexer with valid/ready output, static select or
// round-robin scan of MASK-enabled channels. Scan logic is built only with MUXN_SCAN_EN.
module muxn_scan #(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic       CLK,
    input  logic       RST,
    muxn_scan_if.slave bus
);

    logic [W-1:0]  q_r;
    logic [SW-1:0] qch_r;
    logic          qv_r;

    logic          ld;
    logic          has_word;
    logic [W-1:0]  nxt_q;
    logic [SW-1:0] nxt_ch;

    // The held word may be replaced in the same cycle it is accepted downstream.
    assign ld = bus.CE & (~qv_r | bus.QR);

`ifdef MUXN_SCAN_EN
    logic [SW-1:0] ptr;
    logic [SW-1:0] nxt_ptr;
    logic [SW-1:0] low;
    logic          nxt_qf;
    logic          qf_r;
`else
    logic unused_cfg;
    assign unused_cfg = ^{bus.MODE, bus.MASK};
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        has_word = 1'b1;
        nxt_ch   = bus.S;
        nxt_q    = '0;
`ifdef MUXN_SCAN_EN
        nxt_ptr  = ptr;
        nxt_qf   = 1'b0;
        low      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.MASK[k]) low = SW'(k);
        end
        if (bus.MODE) begin
            has_word = 1'b0;
            // Search starts just after the last served channel and wraps at N.
            for (int i = 1; i <= N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (!has_word && bus.MASK[k] && ((int'(ptr) + i) % N == k)) begin
                        has_word = 1'b1;
                        nxt_ch   = SW'(k);
                        nxt_ptr  = SW'(k);
                    end
                end
            end
            nxt_qf = has_word && (nxt_ch == low);
        end
`endif
        // Out-of-range select leaves nxt_q at zero.
        for (int k = 0; k < N; k++) begin
            if (nxt_ch == SW'(k)) nxt_q = bus.D[k*W +: W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q_r   <= '0;
            qch_r <= '0;
            qv_r  <= 1'b0;
        end else if (ld && has_word) begin
            q_r   <= nxt_q;
            qch_r <= nxt_ch;
            qv_r  <= 1'b1;
        end else if (qv_r && bus.QR) begin
            qv_r  <= 1'b0;
        end
    end

`ifdef MUXN_SCAN_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr  <= SW'(N - 1);
            qf_r <= 1'b0;
        end else if (ld && has_word) begin
            ptr  <= nxt_ptr;
            qf_r <= nxt_qf;
        end
    end
    assign bus.QF = qf_r;
`else
    assign bus.QF = 1'b0;
`endif

    assign bus.Q   = q_r;
    assign bus.QCH = qch_r;
    assign bus.QV  = qv_r;

endmodule

// File: doc/muxn_scan.md
# muxn_scan

Parametrised N-channel, W-bit multiplexer with a registered output and a valid/ready handshake. It supersedes the fixed 4x16 output-latched multiplexers in the DSP datapath. Besides static select, it can scan the enabled channels round-robin, producing a time-division stream of tagged words for a single downstream consumer such as a FIFO, CIC/FIR input or host interface.

## Interface
- W, 16, data width per channel
- N, 4, number of input channels (2..16)
- SW, 2, select/tag width, ceil(log2(N)); integrator sets consistently with N
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-low reset
- CE  input  1  clock enable / load request
- D  input  N*W  channel data, channel k in D[k*W+W-1:k*W]
- S  input  SW  static channel select
- MODE  input  1  0 = static select, 1 = round-robin scan
- MASK  input  N  scan enable per channel, bit k = channel k
- QR  input  1  downstream ready
- Q  output  W  registered output word
- QCH  output  SW  channel index of Q
- QV  output  1  Q/QCH/QF valid
- QF  output  1  first-of-frame flag for the scan word

## Operation
- Reset (RST low, async): Q=0, QCH=0, QV=0, QF=0, internal pointer PTR=N-1.
- Load condition: LD = CE & (~QV | QR). The output register holds while QV=1 and QR=0, whatever CE does.
- Accept without reload: if QV=1, QR=1 and LD yields no word (CE=0, or scan with MASK=0), QV clears on the next edge. Q/QCH hold their last value.
- Static mode (MODE=0) on LD:
  - Q <= D[S], QCH <= S, QV <= 1, QF <= 0.
  - If S >= N: Q <= 0, QCH <= S.
  - PTR is unchanged.
- Scan mode (MODE=1) on LD:
  - Search order is PTR+1, PTR+2, ... modulo N, ending with PTR itself.
  - Select the first channel c in that order with MASK[c]=1.
  - Q <= D[c], QCH <= c, QV <= 1, PTR <= c.
  - QF <= 1 iff c is the lowest set bit of MASK; otherwise QF <= 0.
  - If MASK=0: no load, PTR holds, and the accept rule above applies.
- A single enabled channel repeats every load with QF=1.
- MODE, S and MASK are sampled only at LD. Changing them never alters a word already held. PTR persists across mode changes.
- Reset mid-transfer discards the held word: QV=0 immediately (asynchronously).

## Timing
- Latency: 1 CLK from the LD edge to Q/QCH/QF/QV.
- Throughput: 1 word/cycle when CE=1 and QR=1 continuously.
- QR is combinationally used in LD. Q, QCH, QV and QF are pure register outputs with no combinational path from any input.
- Back-to-back: with QV=1, QR=1 and CE=1, the new word replaces the old at the same edge and QV stays 1.
- Scan wrap: after channel N-1 (or the highest enabled channel), the next load selects the lowest enabled channel and QF=1.
- Non-power-of-two N: PTR arithmetic wraps at N, not at 2^SW.

## Configuration
- MUXN_SCAN_EN defined: scan mode, PTR, the round-robin search and QF logic are compiled in, with behaviour as above.
- MUXN_SCAN_EN undefined:
  - MODE and MASK are ignored and the block always operates in static mode.
  - QF is tied to 0 and no PTR register exists.
  - Ports remain present so instantiations are unchanged.

## Test plan
All scenarios use W=16, N=4, with D3..D0 = 0x3333, 0x2222, 0x1111, 0x0000.
- Reset: RST low mid-stream with QV=1 -> Q=0x0000, QCH=0, QV=0 and QF=0 immediately. After release with MODE=1, MASK=0xF, CE=1, QR=1, the first word is QCH=0, QF=1.
- Static: MODE=0, S=2, CE=1 for one cycle -> next cycle Q=0x2222, QCH=2, QV=1. Then CE=0, QR=1 -> QV=0 the following cycle.
- Backpressure: QV=1, QR=0, CE=1, S changes 2->1 -> Q stays 0x2222 until QR=1, then Q=0x1111 one cycle later.
- Scan with mask: MODE=1, MASK=0b1010, CE=QR=1 -> QCH sequence 1,3,1,3 with QF=1,0,1,0 and Q alternating 0x1111/0x3333.
- Empty mask: MODE=1, MASK=0 while QV=1, QR=1 -> QV=0 next cycle with no new word. Restoring MASK=0b0100 -> Q=0x2222, QCH=2, QF=1.
- Config off (MUXN_SCAN_EN undefined): MODE=1, MASK=0b0001, S=3 -> Q=0x3333, QCH=3, QF=0.
